trap_ctrl: RTL and testbench

Trap sequencer for the machine-mode CSR file. It accepts exception, `mret` and timer-interrupt events from the pipeline and drains the pipeline. It then issues the single-cycle update strobe and next-values for mcause/mepc/mstatus to the CSR file, and redirects fetch to the trap vector or the return address. It sits between the writeback stage, the CLINT and the IFU redirect port.

---
 rtl/trap_ctrl_pkg.sv | 35 +++
 rtl/trap_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// FSM state encoding, event kinds and mcause constants.
package trap_ctrl_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INT_BIT = XLEN - 1;

    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;

    // Clears the two low bits of a pc or vector base.
    localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrain  = 2'd1,
        StUpdate = 2'd2,
        StRedir  = 2'd3
    } trap_state_e;

    typedef enum logic [1:0] {
        KindExc  = 2'd0,
        KindMret = 2'd1,
        KindIrq  = 2'd2
    } trap_kind_e;

    function automatic logic [XLEN-1:0] irq_mcause();
        logic [XLEN-1:0] c;
        c          = {{(XLEN-4){1'b0}}, CAUSE_MTI};
        c[INT_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts exception / mret / timer-interrupt events, drains, updates CSRs, redirects.
// Define TRAP_TIMER_IRQ_EN to enable the timer-interrupt path; otherwise the irq inputs are ignored.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_valid,
    input  logic            irq_mtip,
    input  logic [XLEN-1:0] irq_pc,
    input  logic            irq_pc_valid,
    output logic            req_ready,
    input  logic            pipe_empty,
    input  logic            gIntEn,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            csrUpdata,
    output logic [XLEN-1:0] mcause_n,
    output logic [XLEN-1:0] mepc_n,
    output logic            mstatus_n,
    output logic            stall,
    output logic            flush,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready
);

    trap_state_e     state_q, state_d;
    trap_kind_e      kind_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            mstatus_q;
    logic            irq_req;
    logic            accept;

`ifdef TRAP_TIMER_IRQ_EN
    assign irq_req = irq_mtip & gIntEn & irq_pc_valid & ~exc_valid & ~mret_valid;
`else
    logic unused_irq;
    assign unused_irq = ^{irq_mtip, irq_pc, irq_pc_valid, gIntEn};
    assign irq_req    = 1'b0;
`endif

    assign accept = (state_q == StIdle) & (exc_valid | mret_valid | irq_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept)      state_d = StDrain;
            StDrain:  if (pipe_empty)  state_d = StUpdate;
            StUpdate:                  state_d = StRedir;
            StRedir:  if (redir_ready) state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        stall       = 1'b0;
        csrUpdata   = 1'b0;
        flush       = 1'b0;
        redir_valid = 1'b0;
        unique case (state_q)
            StIdle:   req_ready = 1'b1;
            StDrain:  stall     = 1'b1;
            StUpdate: begin
                stall     = 1'b1;
                csrUpdata = 1'b1;
                flush     = 1'b1;
            end
            StRedir: begin
                stall       = 1'b1;
                redir_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Next CSR values are captured at accept so later input changes cannot disturb the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q    <= KindExc;
            mcause_q  <= '0;
            mepc_q    <= '0;
            mstatus_q <= 1'b0;
        end else if (accept) begin
            if (exc_valid) begin
                kind_q    <= KindExc;
                mcause_q  <= {{(XLEN-4){1'b0}}, exc_cause};
                mepc_q    <= exc_pc & ALIGN4_MASK;
                mstatus_q <= 1'b1;
            end else if (mret_valid) begin
                kind_q    <= KindMret;
                mcause_q  <= '0;
                mepc_q    <= csr_mepc;
                mstatus_q <= 1'b0;
            end else begin
                kind_q    <= KindIrq;
                mcause_q  <= irq_mcause();
                mepc_q    <= irq_pc;
                mstatus_q <= 1'b1;
            end
        end
    end

    // Target is registered on the way into REDIR so it stays stable for the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_pc_q <= '0;
        end else if (state_q == StUpdate) begin
            redir_pc_q <= (kind_q == KindMret) ? csr_mepc : (csr_mtvec & ALIGN4_MASK);
        end
    end

    assign mcause_n  = mcause_q;
    assign mepc_n    = mepc_q;
    assign mstatus_n = mstatus_q;
    assign redir_pc  = redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events against a reference model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int unsigned W = XLEN;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         exc_valid = 1'b0;
    logic [3:0]   exc_cause = '0;
    logic [W-1:0] exc_pc = '0;
    logic         mret_valid = 1'b0;
    logic         irq_mtip = 1'b0;
    logic [W-1:0] irq_pc = '0;
    logic         irq_pc_valid = 1'b0;
    logic         req_ready;
    logic         pipe_empty = 1'b1;
    logic         gIntEn = 1'b0;
    logic [W-1:0] csr_mtvec = '0;
    logic [W-1:0] csr_mepc = '0;
    logic         csrUpdata;
    logic [W-1:0] mcause_n;
    logic [W-1:0] mepc_n;
    logic         mstatus_n;
    logic         stall;
    logic         flush;
    logic         redir_valid;
    logic [W-1:0] redir_pc;
    logic         redir_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_pc      (exc_pc),
        .mret_valid  (mret_valid),
        .irq_mtip    (irq_mtip),
        .irq_pc      (irq_pc),
        .irq_pc_valid(irq_pc_valid),
        .req_ready   (req_ready),
        .pipe_empty  (pipe_empty),
        .gIntEn      (gIntEn),
        .csr_mtvec   (csr_mtvec),
        .csr_mepc    (csr_mepc),
        .csrUpdata   (csrUpdata),
        .mcause_n    (mcause_n),
        .mepc_n      (mepc_n),
        .mstatus_n   (mstatus_n),
        .stall       (stall),
        .flush       (flush),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready)
    );

    // kind: 0 none, 1 exception, 2 mret, 3 interrupt
    typedef struct packed {
        logic [1:0]   kind;
        logic [W-1:0] mcause;
        logic [W-1:0] mepc;
        logic [W-1:0] rpc;
        logic         mstatus;
    } exp_t;

    function automatic exp_t model();
        exp_t e;
        bit   irq_on;
`ifdef TRAP_TIMER_IRQ_EN
        irq_on = 1'b1;
`else
        irq_on = 1'b0;
`endif
        e = '0;
        if (exc_valid) begin
            e.kind    = 2'd1;
            e.mcause  = W'(exc_cause);
            e.mepc    = exc_pc - (exc_pc % 4);
            e.rpc     = csr_mtvec - (csr_mtvec % 4);
            e.mstatus = 1'b1;
        end else if (mret_valid) begin
            e.kind    = 2'd2;
            e.mcause  = '0;
            e.mepc    = csr_mepc;
            e.rpc     = csr_mepc;
            e.mstatus = 1'b0;
        end else if (irq_on && irq_mtip && gIntEn && irq_pc_valid) begin
            e.kind    = 2'd3;
            e.mcause  = (64'd1 << 63) + 64'd7;
            e.mepc    = irq_pc;
            e.rpc     = csr_mtvec - (csr_mtvec % 4);
            e.mstatus = 1'b1;
        end
        return e;
    endfunction

    // Observations gathered by run_seq; compared inside each test.
    logic         obs_ready, obs_mstatus, obs_stable, obs_stall_ok, obs_flush_ok;
    logic         obs_hold_ok, obs_timeout, obs_idle_after;
    logic [W-1:0] obs_mcause, obs_mepc, obs_rpc;
    int           obs_pulses, obs_upd_cyc, obs_redir_cyc, obs_rcount;

    // Starts just after a negedge with request inputs set; ends just after a negedge back in idle.
    task automatic run_seq(input exp_t e, input int dw, input int rw);
        int cyc;
        bit done;
        obs_ready = req_ready;
        obs_pulses = 0; obs_upd_cyc = -1; obs_redir_cyc = -1; obs_rcount = 0;
        obs_stable = 1'b1; obs_stall_ok = 1'b1; obs_flush_ok = 1'b1; obs_hold_ok = 1'b1;
        obs_mcause = '0; obs_mepc = '0; obs_rpc = '0; obs_mstatus = 1'b0;
        cyc = 0;
        done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        while (!done && cyc < 100) begin
            cyc++;
            if (cyc == 1) begin
                if (e.kind == 2'd1) exc_valid = 1'b0;
                if (e.kind == 2'd2) mret_valid = 1'b0;
                if (e.kind == 2'd3) irq_mtip = 1'b0;
            end
            if (stall !== 1'b1) obs_stall_ok = 1'b0;
            if (csrUpdata === 1'b1) begin
                obs_pulses++;
                obs_upd_cyc = cyc;
                obs_mcause  = mcause_n;
                obs_mepc    = mepc_n;
                obs_mstatus = mstatus_n;
                if (flush !== 1'b1) obs_flush_ok = 1'b0;
            end else if (flush !== 1'b0) begin
                obs_flush_ok = 1'b0;
            end
            if (redir_valid === 1'b1) begin
                obs_rcount++;
                if (obs_rcount == 1) begin
                    obs_rpc = redir_pc;
                    obs_redir_cyc = cyc;
                end else if (redir_pc !== obs_rpc) begin
                    obs_stable = 1'b0;
                end
                if (mcause_n !== obs_mcause || mepc_n !== obs_mepc) obs_hold_ok = 1'b0;
                redir_ready = (obs_rcount > rw);
                done = redir_ready;
            end else begin
                redir_ready = 1'b0;
            end
            pipe_empty = (cyc > dw);
            @(negedge clk);
        end
        obs_timeout = !done;
        redir_ready = 1'b0;
        pipe_empty = 1'b1;
        obs_idle_after = (req_ready === 1'b1) && (stall === 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b1 || csrUpdata !== 1'b0 || flush !== 1'b0 || stall !== 1'b0 ||
            redir_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got rdy=%b upd=%b fl=%b st=%b rv=%b want 1 0 0 0 0",
                     req_ready, csrUpdata, flush, stall, redir_valid);
        end
        checks++;
        if (mcause_n !== '0 || mepc_n !== '0 || redir_pc !== '0 || mstatus_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got mcause=%h mepc=%h rpc=%h ms=%b want all 0",
                     mcause_n, mepc_n, redir_pc, mstatus_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ecall();
        exp_t e;
        exc_valid = 1'b1; exc_cause = CAUSE_ECALL_M; exc_pc = 64'h8000_0010;
        csr_mtvec = 64'h8000_0100; pipe_empty = 1'b1;
        e = model();
        run_seq(e, 0, 0);
        checks++;
        if (obs_ready !== 1'b1 || obs_timeout) begin
            errors++; $display("FAIL ecall_accept got rdy=%b timeout=%b want 1 0", obs_ready, obs_timeout);
        end
        checks++;
        if (obs_pulses != 1) begin
            errors++; $display("FAIL ecall_pulses got %0d want 1", obs_pulses);
        end
        checks++;
        if (obs_mcause !== 64'd11 || obs_mepc !== 64'h8000_0010 || obs_mstatus !== 1'b1) begin
            errors++;
            $display("FAIL ecall_csr got mcause=%h mepc=%h ms=%b want 11 80000010 1",
                     obs_mcause, obs_mepc, obs_mstatus);
        end
        checks++;
        if (obs_rpc !== 64'h8000_0100 || obs_redir_cyc != 3) begin
            errors++;
            $display("FAIL ecall_redir got pc=%h cyc=%0d want 80000100 3", obs_rpc, obs_redir_cyc);
        end
        checks++;
        if (!obs_stall_ok || !obs_flush_ok || !obs_idle_after) begin
            errors++;
            $display("FAIL ecall_strobes got stall_ok=%b flush_ok=%b idle=%b want 1 1 1",
                     obs_stall_ok, obs_flush_ok, obs_idle_after);
        end
    endtask

    task automatic test_mret();
        exp_t e;
        mret_valid = 1'b1; csr_mepc = 64'h8000_0014;
        e = model();
        run_seq(e, 0, 0);
        checks++;
        if (obs_pulses != 1 || obs_mstatus !== 1'b0 || obs_mepc !== 64'h8000_0014) begin
            errors++;
            $display("FAIL mret_csr got pulses=%0d ms=%b mepc=%h want 1 0 80000014",
                     obs_pulses, obs_mstatus, obs_mepc);
        end
        checks++;
        if (obs_rpc !== 64'h8000_0014 || obs_redir_cyc != 3) begin
            errors++;
            $display("FAIL mret_redir got pc=%h cyc=%0d want 80000014 3", obs_rpc, obs_redir_cyc);
        end
    endtask

    task automatic test_irq();
        exp_t e;
        // Masked interrupt is never accepted in either build.
        irq_mtip = 1'b1; irq_pc_valid = 1'b1; irq_pc = 64'h8000_0200; gIntEn = 1'b0;
        csr_mtvec = 64'h8000_0103;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || stall !== 1'b0) begin
                errors++;
                $display("FAIL irq_masked got rdy=%b stall=%b want 1 0", req_ready, stall);
            end
        end
        gIntEn = 1'b1;
        e = model();
        if (e.kind == 2'd3) begin
            run_seq(e, 1, 1);
            checks++;
            if (obs_pulses != 1 || obs_mcause !== 64'h8000_0000_0000_0007 ||
                obs_mepc !== 64'h8000_0200 || obs_mstatus !== 1'b1) begin
                errors++;
                $display("FAIL irq_csr got n=%0d mcause=%h mepc=%h ms=%b want 1 8000000000000007 80000200 1",
                         obs_pulses, obs_mcause, obs_mepc, obs_mstatus);
            end
            checks++;
            if (obs_rpc !== 64'h8000_0100 || obs_timeout) begin
                errors++;
                $display("FAIL irq_redir got pc=%h timeout=%b want 80000100 0", obs_rpc, obs_timeout);
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                checks++;
                if (req_ready !== 1'b1 || stall !== 1'b0 || csrUpdata !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_disabled got rdy=%b stall=%b upd=%b want 1 0 0",
                             req_ready, stall, csrUpdata);
                end
            end
        end
        irq_mtip = 1'b0; irq_pc_valid = 1'b0; gIntEn = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e;
        exc_valid = 1'b1; exc_cause = CAUSE_EBREAK; exc_pc = 64'h8000_0033;
        mret_valid = 1'b1; csr_mepc = 64'h8000_0444;
        irq_mtip = 1'b1; gIntEn = 1'b1; irq_pc_valid = 1'b1; irq_pc = 64'h8000_0500;
        csr_mtvec = 64'h8000_0100;
        e = model();
        run_seq(e, 0, 0);
        checks++;
        if (obs_mcause !== 64'd3 || obs_mepc !== 64'h8000_0030 || obs_mstatus !== 1'b1) begin
            errors++;
            $display("FAIL prio_exc got mcause=%h mepc=%h ms=%b want 3 80000030 1",
                     obs_mcause, obs_mepc, obs_mstatus);
        end
        e = model();
        run_seq(e, 0, 0);
        checks++;
        if (obs_pulses != 1 || obs_mstatus !== 1'b0 || obs_rpc !== 64'h8000_0444) begin
            errors++;
            $display("FAIL prio_mret got n=%0d ms=%b pc=%h want 1 0 80000444",
                     obs_pulses, obs_mstatus, obs_rpc);
        end
        irq_mtip = 1'b0; irq_pc_valid = 1'b0; gIntEn = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        exc_valid = 1'b1; exc_cause = CAUSE_ECALL_M; exc_pc = 64'h8000_0abc;
        csr_mtvec = 64'h8000_0200; pipe_empty = 1'b0;
        e = model();
        run_seq(e, 5, 3);
        checks++;
        if (obs_upd_cyc != 7 || obs_redir_cyc != 8 || obs_rcount != 4) begin
            errors++;
            $display("FAIL bp_timing got upd=%0d redir=%0d hs=%0d want 7 8 4",
                     obs_upd_cyc, obs_redir_cyc, obs_rcount);
        end
        checks++;
        if (!obs_stable || !obs_stall_ok || !obs_hold_ok || obs_rpc !== 64'h8000_0200) begin
            errors++;
            $display("FAIL bp_stable got stable=%b stall=%b hold=%b pc=%h want 1 1 1 80000200",
                     obs_stable, obs_stall_ok, obs_hold_ok, obs_rpc);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        exc_valid = 1'b1; exc_cause = CAUSE_EBREAK; exc_pc = 64'h8000_0f00; pipe_empty = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exc_valid = 1'b0;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL rst_mid_drain got stall=%b want 1", stall);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || csrUpdata !== 1'b0 || flush !== 1'b0 ||
            redir_valid !== 1'b0 || mepc_n !== '0) begin
            errors++;
            $display("FAIL rst_mid_state got rdy=%b st=%b upd=%b fl=%b rv=%b mepc=%h want 1 0 0 0 0 0",
                     req_ready, stall, csrUpdata, flush, redir_valid, mepc_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pipe_empty = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (csrUpdata === 1'b1 || req_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_mid_after got bad_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int dw, rw;
        for (int it = 0; it < 24; it++) begin
            exc_valid    = ($urandom_range(0, 3) == 0);
            mret_valid   = ($urandom_range(0, 2) == 0);
            irq_mtip     = $urandom_range(0, 1);
            gIntEn       = $urandom_range(0, 1);
            irq_pc_valid = $urandom_range(0, 1);
            exc_cause    = 4'($urandom_range(0, 15));
            exc_pc       = {$urandom, $urandom};
            irq_pc       = {$urandom, $urandom};
            csr_mtvec    = {$urandom, $urandom};
            csr_mepc     = {$urandom, $urandom};
            pipe_empty   = $urandom_range(0, 1);
            dw = $urandom_range(0, 4);
            rw = $urandom_range(0, 3);
            e = model();
            if (e.kind == 2'd0) begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (req_ready !== 1'b1 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_idle got rdy=%b stall=%b want 1 0", it, req_ready, stall);
                end
            end else begin
                run_seq(e, dw, rw);
                checks++;
                if (obs_pulses != 1 || obs_mcause !== e.mcause || obs_mepc !== e.mepc ||
                    obs_mstatus !== e.mstatus) begin
                    errors++;
                    $display("FAIL rnd%0d_csr got n=%0d mc=%h me=%h ms=%b want 1 %h %h %b", it,
                             obs_pulses, obs_mcause, obs_mepc, obs_mstatus, e.mcause, e.mepc, e.mstatus);
                end
                checks++;
                if (obs_rpc !== e.rpc || obs_redir_cyc != 3 + dw || obs_rcount != rw + 1 ||
                    obs_timeout) begin
                    errors++;
                    $display("FAIL rnd%0d_redir got pc=%h cyc=%0d hs=%0d want %h %0d %0d", it,
                             obs_rpc, obs_redir_cyc, obs_rcount, e.rpc, 3 + dw, rw + 1);
                end
                checks++;
                if (!obs_stable || !obs_stall_ok || !obs_flush_ok || !obs_hold_ok ||
                    !obs_idle_after) begin
                    errors++;
                    $display("FAIL rnd%0d_flags got st=%b sk=%b fl=%b hd=%b id=%b want 1 1 1 1 1", it,
                             obs_stable, obs_stall_ok, obs_flush_ok, obs_hold_ok, obs_idle_after);
                end
            end
            exc_valid = 1'b0; mret_valid = 1'b0; irq_mtip = 1'b0;
            irq_pc_valid = 1'b0; gIntEn = 1'b0; pipe_empty = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_irq();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
